// File: rtl/adder_pkg.sv
// Shared types and constants for the registered ripple-carry adder.
package adder_pkg;

    localparam int ADDER_DEFAULT_WIDTH = 8;

    typedef logic [ADDER_DEFAULT_WIDTH-1:0] adder_operand_t;

    typedef struct packed {
        logic           carry;
        adder_operand_t sum;
    } adder_result_t;

    // Bit index where the optional pipeline register cuts the carry chain.
    function automatic int adder_split_point(input int width);
        return width / 2;
    endfunction

endpackage

// File: rtl/adder_bit_cell.sv
// One-bit full adder, purely combinational.
// Latency: none. Backpressure: none.
module adder_bit_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/adder.sv
// Registered unsigned ripple-carry adder: {carry_out, sum_out} = in1 + in0.
// Latency: 1 cycle, or 2 with ADDER_PIPE_EN (chain split at WIDTH/2). Throughput 1/cycle.
// Backpressure: none; every in_valid edge is accepted.
module adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in0,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             out_valid
);

    localparam int LO = adder_split_point(WIDTH);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             vld_q, vld_d;

    assign c[0] = 1'b0;

`ifdef ADDER_PIPE_EN
    localparam logic [WIDTH-1:0] LO_MASK = (WIDTH'(1) << LO) - WIDTH'(1);

    logic              vld1_q, vld1_d;
    logic              mid_c_q, mid_c_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [WIDTH-1:LO] hi_a_q, hi_a_d;
    logic [WIDTH-1:LO] hi_b_q, hi_b_d;

    // Low cells see live operands; high cells see the stage-1 registers.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        if (i < LO) begin : g_lo
            adder_bit_cell u_cell (
                .a    (in1[i]),
                .b    (in0[i]),
                .cin  (c[i]),
                .s    (s[i]),
                .cout (c[i+1])
            );
        end else begin : g_hi
            adder_bit_cell u_cell (
                .a    (hi_a_q[i]),
                .b    (hi_b_q[i]),
                .cin  ((i == LO) ? mid_c_q : c[i]),
                .s    (s[i]),
                .cout (c[i+1])
            );
        end
    end

    always_comb begin
        vld1_d  = in_valid;
        mid_c_d = mid_c_q;
        lo_d    = lo_q;
        hi_a_d  = hi_a_q;
        hi_b_d  = hi_b_q;
        if (in_valid) begin
            mid_c_d = c[LO];
            lo_d    = s & LO_MASK;
            hi_a_d  = in1[WIDTH-1:LO];
            hi_b_d  = in0[WIDTH-1:LO];
        end

        vld_d   = vld1_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        if (vld1_q) begin
            sum_d   = (s & ~LO_MASK) | (lo_q & LO_MASK);
            carry_d = c[WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld1_q  <= 1'b0;
            mid_c_q <= 1'b0;
            lo_q    <= '0;
            hi_a_q  <= '0;
            hi_b_q  <= '0;
        end else begin
            vld1_q  <= vld1_d;
            mid_c_q <= mid_c_d;
            lo_q    <= lo_d;
            hi_a_q  <= hi_a_d;
            hi_b_q  <= hi_b_d;
        end
    end
`else
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        adder_bit_cell u_cell (
            .a    (in1[i]),
            .b    (in0[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    always_comb begin
        vld_d   = in_valid;
        sum_d   = sum_q;
        carry_d = carry_q;
        if (in_valid) begin
            sum_d   = s;
            carry_d = c[WIDTH];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            vld_q   <= vld_d;
        end
    end

    assign sum_out   = sum_q;
    assign carry_out = carry_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: directed vectors, corner sequences and random traffic vs a queue model.
module tb_adder;
    import adder_pkg::*;

`ifdef ADDER_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    adder_operand_t in1 = '0;
    adder_operand_t in0 = '0;
    logic [7:0]     sum_out;
    logic           carry_out;
    logic           out_valid;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in1       (in1),
        .in0       (in0),
        .sum_out   (sum_out),
        .carry_out (carry_out),
        .out_valid (out_valid)
    );

    typedef struct packed {
        logic       v;
        logic [8:0] r;
    } pend_t;

    pend_t      q[$];
    logic       exp_v = 1'b0;
    logic [8:0] exp_r = '0;

    typedef struct {
        adder_operand_t a;
        adder_operand_t b;
        adder_result_t  res;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance model, compare all outputs against it.
    task automatic step(input logic r, input logic v, input logic [7:0] a, input logic [7:0] b);
        pend_t p;
        rst_n    = r;
        in_valid = v;
        in1      = a;
        in0      = b;
        @(posedge clk);
        #1;
        if (!r) begin
            q.delete();
            for (int k = 0; k < LAT - 1; k++) q.push_back('0);
            exp_v = 1'b0;
            exp_r = '0;
        end else begin
            q.push_back({v, 9'(a) + 9'(b)});
            p     = q.pop_front();
            exp_v = p.v;
            if (p.v) exp_r = p.r;
        end
        chk("model_sum",   {1'b0, sum_out}, {1'b0, exp_r[7:0]});
        chk("model_carry", {8'd0, carry_out}, {8'd0, exp_r[8]});
        chk("model_valid", {8'd0, out_valid}, {8'd0, exp_v});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 8'($urandom), 8'($urandom));
    endtask

    task automatic chk_out(input string nm, input logic [7:0] s, input logic c, input logic v);
        chk({nm, "_sum"},   {1'b0, sum_out}, {1'b0, s});
        chk({nm, "_carry"}, {8'd0, carry_out}, {8'd0, c});
        chk({nm, "_valid"}, {8'd0, out_valid}, {8'd0, v});
    endtask

    logic [7:0] st_a[4] = '{8'h01, 8'h80, 8'h7F, 8'hAA};
    logic [7:0] st_b[4] = '{8'h01, 8'h80, 8'h01, 8'h55};
    logic [8:0] st_e[4] = '{9'h002, 9'h100, 9'h080, 9'h0FF};

    initial begin
        tbl[0] = '{a: 8'h12, b: 8'h34, res: '{carry: 1'b0, sum: 8'h46}};
        tbl[1] = '{a: 8'hFF, b: 8'h01, res: '{carry: 1'b1, sum: 8'h00}};
        tbl[2] = '{a: 8'hFF, b: 8'hFF, res: '{carry: 1'b1, sum: 8'hFE}};
        tbl[3] = '{a: 8'h00, b: 8'h00, res: '{carry: 1'b0, sum: 8'h00}};

        // Reset held two cycles with random operands
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b1, 8'($urandom), 8'($urandom));
            chk_out("reset", 8'h00, 1'b0, 1'b0);
        end

        // Directed vectors, each drained to the output
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, tbl[i].a, tbl[i].b);
            idle(LAT - 1);
            chk_out($sformatf("vec%0d", i), tbl[i].res.sum, tbl[i].res.carry, 1'b1);
        end

        // Back-to-back stream: one result per cycle, no bubbles
        for (int j = 0; j < 4 + LAT - 1; j++) begin
            if (j < 4) step(1'b1, 1'b1, st_a[j], st_b[j]);
            else       idle(1);
            if (j >= LAT - 1)
                chk_out($sformatf("stream%0d", j - LAT + 1),
                        st_e[j-LAT+1][7:0], st_e[j-LAT+1][8], 1'b1);
        end

        // Hold with changing operands while in_valid is low
        step(1'b1, 1'b1, 8'h12, 8'h34);
        idle(LAT - 1);
        chk_out("hold_load", 8'h46, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            chk_out($sformatf("hold%0d", k), 8'h46, 1'b0, 1'b0);
        end

        // Reset right after issuing a pair discards it
        step(1'b1, 1'b1, 8'hF0, 8'h20);
        step(1'b0, 1'b1, 8'h55, 8'h66);
        chk_out("mid_rst", 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h03, 8'h04);
        if (LAT > 1) chk_out("mid_rst_bubble", 8'h00, 1'b0, 1'b0);
        idle(LAT - 1);
        chk_out("post_rst", 8'h07, 1'b0, 1'b1);

        // Random traffic with occasional resets against the model
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 31) != 0), ($urandom_range(0, 9) < 7),
                 8'($urandom), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
